// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the demux_n slice
package demux_pkg;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_NCH    = 4;
  localparam int DROP_CNT_W = 8;

  // Select width: enough bits to address every channel, never less than one.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry channel register with load, drain and idle gating
module demux_slot #(
  parameter int WIDTH     = 10,
  parameter int ZERO_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Load wins over drain so a same-cycle drain and reload streams without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = (ZERO_IDLE != 0 && !valid_q) ? '0 : data_q;

endmodule

// File: rtl/demux_n.sv
// rtl/demux_n.sv - one-to-N stream demultiplexer with out-of-range drop counting
module demux_n
  import demux_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int NCH       = DEF_NCH,
  parameter  int ZERO_IDLE = 1,
  localparam int SELW      = sel_width(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       sel,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*WIDTH-1:0]  out_data,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  err
);

  localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]    sel_ext;
  logic           sel_ok;
  logic           accept;
  logic           drop;
  logic [NCH-1:0] load;

  assign sel_ext = 32'(sel);
  assign sel_ok  = sel_ext < 32'(NCH);
  assign accept  = in_valid && in_ready;
  assign drop    = accept && !sel_ok;

  // Ready follows the addressed channel; an unaddressable select is always taken and dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (sel_ext == 32'(k)) begin
        in_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign load[k] = accept && (sel_ext == 32'(k));

    demux_slot #(
      .WIDTH     (WIDTH),
      .ZERO_IDLE (ZERO_IDLE)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH])
    );
  end

  // Saturating drop counter and sticky error for discarded out-of-range words.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
